bcd_to_bin_seq: RTL
===================

// Module: bcd_to_bin_seq
// PURPOSE
//  Iterative packed-BCD to binary converter; the inverse of the combinational binary-to-BCD
//  converter ConverterBCD_Comb. It processes one decimal digit per clock, most significant
//  digit first: acc = acc*10 + digit. It sits between the BCD entry/display path and the
//  binary counter/compare logic, using a start/done handshake.
// PARAMETERS
//  DIGITS  10  number of BCD digits on the bcd input (4*DIGITS bits)
//  BIN_W   32  width of the binary result
// PORTS
//  clk        in   1         system clock, rising edge
//  rst        in   1         asynchronous, active-high reset
//  start      in   1         request conversion; sampled only in IDLE (see CONFIGURATION)
//  bcd        in   4*DIGITS  packed BCD operand; digit i = bcd[4i+3:4i]; captured on accepted start
//  busy       out  1         high in CONV and DONE
//  done       out  1         one-cycle pulse; bin/ovf/bad_digit are valid from this cycle on
//  bin        out  BIN_W     binary result; held until the next done
//  ovf        out  1         value exceeded 2^BIN_W-1; held with bin
//  bad_digit  out  1         at least one digit was >9; held with bin
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, bin, ovf and bad_digit all 0; internal shift register,
//   accumulator and digit counter cleared. Reset applies immediately, including mid-conversion.
//   The partial result is discarded, and done does not fire.
//  FSM IDLE -> CONV -> DONE -> IDLE:
//   IDLE: on start=1, capture bcd into the shift register; acc=0; cnt=0; sticky flags cleared;
//    go to CONV.
//   CONV: each cycle, take the top digit d = sreg[4*DIGITS-1 -: 4]; acc <= acc*10 + d;
//    shift sreg left by 4; cnt++. After cnt reaches DIGITS-1, go to DONE (DIGITS cycles total).
//   DONE: bin <= ovf_next ? {BIN_W{1'b1}} : acc[BIN_W-1:0]; ovf, bad_digit updated;
//    done=1 for this cycle only; go to IDLE.
//  Latency: with start sampled at edge N, done is high during the cycle after edge N+DIGITS+1.
//   Throughput is one conversion per DIGITS+2 cycles. start held high re-triggers in IDLE.
//  Arithmetic: the accumulator is BIN_W+4 bits wide; acc*10 = (acc<<3)+(acc<<1).
//   If any intermediate value exceeds 2^BIN_W-1, set sticky ovf, then clamp acc to 2^BIN_W-1
//   so that it cannot wrap.
//  Invalid digit (d>9): set sticky bad_digit; d is still accumulated at face value (10..15).
//   ovf has priority for bin saturation.
//  start in CONV or DONE is ignored (default build). bcd is don't-care except on an
//   accepted start.
// CONFIGURATION
//  BCD2BIN_RESTART_EN defined: start=1 while in CONV restarts the conversion. The new bcd is
//   captured, acc, cnt and flags are cleared, and the state stays CONV. No done is issued for
//   the aborted operand. start in DONE is still ignored.
//  BCD2BIN_RESTART_EN undefined: start is honoured in IDLE only.
// TESTING
//  T1 bcd=40'h0000000000, start pulse -> done exactly DIGITS+1 cycles after the start edge,
//   bin=0, ovf=0, bad_digit=0
//  T2 bcd=40'h4294967295 -> bin=32'hFFFFFFFF, ovf=0. Then bcd=40'h4294967296 ->
//   bin=32'hFFFFFFFF, ovf=1. Then bcd=40'h9999999999 -> ovf=1
//  T3 bcd=40'h000000001A -> bad_digit=1, bin=20. The next conversion of 40'h0000000123 ->
//   bad_digit=0, bin=123
//  T4 rst pulse 4 cycles into CONV -> all outputs 0 immediately, no done. A fresh start then
//   converts normally
//  T5 start re-pulsed mid-CONV with new operand 40'h0000000777. Default build: done with
//   the first result, then 777 only after a new start in IDLE. With BCD2BIN_RESTART_EN:
//   a single done, bin=777
//  T6 round trip: drive ConverterBCD_Comb with an incrementing 32-bit count plus random values.
//   Feed its bcd output here -> bin equals the original count, ovf=0, bad_digit=0 for every
//   sample

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
//   Iterative packed-BCD to binary converter. One decimal digit is folded into
//   the accumulator per clock, most significant digit first (acc = acc*10 + d).
//   A start/done handshake is used.
//
//   Optional feature macro: BCD2BIN_RESTART_EN
//     When defined, start=1 during CONV restarts the conversion with a freshly
//     captured operand. When undefined, start is honoured in IDLE only.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   conversion request
//   bcd        in   packed BCD operand, digit i = bcd[4i+3:4i]
//   busy       out  high while converting (CONV and DONE)
//   done       out  one-cycle pulse; bin/ovf/bad_digit valid from this cycle
//   bin        out  binary result, held until the next done
//   ovf        out  result exceeded 2^BIN_W-1 (bin saturated)
//   bad_digit  out  at least one digit was greater than 9
//
// State table
//   IDLE | waiting for start
//   CONV | folding one digit per cycle into the accumulator
//   DONE | publishing the result; done pulses in the following cycle

module bcd_to_bin_seq #(
  parameter int DIGITS = 10,
  parameter int BIN_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin,
  output logic                  ovf,
  output logic                  bad_digit
);

  localparam int ACC_W = BIN_W + 4;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {4'h0, {BIN_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [4*DIGITS-1:0] sreg;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_s;
  logic                bad_s;

  logic                load;
  logic                step;
  logic [3:0]          digit;
  logic [ACC_W-1:0]    acc_mul;
  logic                acc_ovf;
  logic [ACC_W-1:0]    acc_sat;

  // acc is always clamped to 2^BIN_W-1, so acc*10+15 stays below 2^(BIN_W+4)
  // and the upper nibble alone detects overflow.
  assign digit   = sreg[4*DIGITS-1 -: 4];
  assign acc_mul = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, digit};
  assign acc_ovf = |acc_mul[ACC_W-1:BIN_W];
  assign acc_sat = acc_ovf ? ACC_MAX : acc_mul;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
`ifdef BCD2BIN_RESTART_EN
        if (start) begin
          load = 1'b1;
        end else begin
          step = 1'b1;
          if (cnt == CNT_LAST) begin
            state_next = DONE;
          end
        end
`else
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          state_next = DONE;
        end
`endif
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
      ovf_s <= 1'b0;
      bad_s <= 1'b0;
    end else if (load) begin
      sreg  <= bcd;
      acc   <= '0;
      cnt   <= '0;
      ovf_s <= 1'b0;
      bad_s <= 1'b0;
    end else if (step) begin
      sreg  <= {sreg[4*DIGITS-5:0], 4'h0};
      acc   <= acc_sat;
      cnt   <= cnt + CNT_W'(1);
      ovf_s <= ovf_s | acc_ovf;
      bad_s <= bad_s | (digit > 4'd9);
    end
  end

  // Results are registered on leaving DONE so that done and the new bin
  // appear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      bin       <= '0;
      ovf       <= 1'b0;
      bad_digit <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        bin       <= ovf_s ? {BIN_W{1'b1}} : acc[BIN_W-1:0];
        ovf       <= ovf_s;
        bad_digit <= bad_s;
      end
    end
  end

endmodule
